// File: rtl/channel_serial_buffer.sv
// Inter-layer buffer: circular FIFO of full input words feeding a channel-group serialiser.
// Each word is emitted as NUM_CHANNEL/OUT_CHANNEL slices, least-significant group first.
module channel_serial_buffer #(
    parameter int unsigned BIT_WIDTH    = 8,
    parameter int unsigned NUM_CHANNEL  = 4,
    parameter int unsigned OUT_CHANNEL  = 1,
    parameter int unsigned BUFFER_DEPTH = 8,
    parameter int unsigned AFULL_THRESH = 6,
    parameter bit          BYPASS_EN    = 1'b1
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_flush,
    input  logic                                    i_prev_layer_valid,
    output logic                                    o_prev_layer_rdy,
    input  logic [NUM_CHANNEL*BIT_WIDTH-1:0]        i_prev_layer_data,
    input  logic                                    i_next_layer_rdy,
    output logic                                    o_next_layer_valid,
    output logic [OUT_CHANNEL*BIT_WIDTH-1:0]        o_next_layer_data,
    output logic                                    o_next_layer_last,
    output logic [$clog2(BUFFER_DEPTH+1)-1:0]       o_occupancy,
    output logic                                    o_almost_full
);

    localparam int unsigned RATIO = NUM_CHANNEL / OUT_CHANNEL;
    localparam int unsigned IN_W  = NUM_CHANNEL * BIT_WIDTH;
    localparam int unsigned OUT_W = OUT_CHANNEL * BIT_WIDTH;
    localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);
    localparam int unsigned SEL_W = (RATIO > 1) ? $clog2(RATIO) : 1;

    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(BUFFER_DEPTH);
    localparam logic [CNT_W-1:0] CNT_AFULL = CNT_W'(AFULL_THRESH);
    localparam logic [SEL_W-1:0] SEL_LAST  = SEL_W'(RATIO - 1);

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t                 r_state, w_state_next;
    logic [PTR_W-1:0]       r_wr_ptr, r_rd_ptr;
    logic [CNT_W-1:0]       r_count, w_count_next;
    logic [SEL_W-1:0]       r_sel, w_sel_next;
    logic [IN_W-1:0]        r_stage;
    logic [IN_W-1:0]        r_mem [BUFFER_DEPTH];
    logic [RATIO-1:0][OUT_W-1:0] w_groups;

    logic w_fifo_empty, w_in_xfer, w_out_xfer, w_sel_last;
    logic w_stage_free, w_pop, w_bypass, w_push;

    assign w_fifo_empty       = (r_count == '0);
    assign o_prev_layer_rdy   = (r_count < CNT_FULL) && !i_flush;
    assign o_next_layer_valid = (r_state == S_SEND) && !i_flush;
    assign w_in_xfer          = i_prev_layer_valid && o_prev_layer_rdy;
    assign w_out_xfer         = o_next_layer_valid && i_next_layer_rdy;
    assign w_sel_last         = (r_sel == SEL_LAST);

    // Stage can take a new word when idle or while its final slice leaves this cycle.
    assign w_stage_free = !i_flush && ((r_state == S_EMPTY) || (w_out_xfer && w_sel_last));
    assign w_pop        = w_stage_free && !w_fifo_empty;
    assign w_bypass     = BYPASS_EN && w_stage_free && w_fifo_empty && w_in_xfer;
    assign w_push       = w_in_xfer && !w_bypass;

    assign w_groups          = r_stage;
    assign o_next_layer_data = (r_state == S_SEND) ? w_groups[r_sel] : '0;
    assign o_next_layer_last = o_next_layer_valid && w_sel_last;
    assign o_occupancy       = r_count;
    assign o_almost_full     = (r_count >= CNT_AFULL);

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        if (i_flush) begin
            w_state_next = S_EMPTY;
            w_sel_next   = '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_pop || w_bypass) begin
                        w_state_next = S_SEND;
                        w_sel_next   = '0;
                    end
                end
                S_SEND: begin
                    if (w_out_xfer) begin
                        if (!w_sel_last) begin
                            w_sel_next = r_sel + 1'b1;
                        end else begin
                            w_sel_next = '0;
                            if (!(w_pop || w_bypass)) w_state_next = S_EMPTY;
                        end
                    end
                end
                default: begin
                    w_state_next = S_EMPTY;
                    w_sel_next   = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_count_next = r_count;
        if (i_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + 1'b1;
        end else if (w_pop && !w_push) begin
            w_count_next = r_count - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_EMPTY;
            r_sel    <= '0;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_count <= w_count_next;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: output data is masked while the stage is empty.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_prev_layer_data;
        if (w_pop) begin
            r_stage <= r_mem[r_rd_ptr];
        end else if (w_bypass) begin
            r_stage <= i_prev_layer_data;
        end
    end

endmodule

// File: tb/tb_channel_serial_buffer.sv
// Self-checking bench: three buffer configurations (default, 2:1 ratio with depth 5, no bypass)
// exercised by directed scenarios and a randomised queue-based scoreboard.
module tb_channel_serial_buffer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // A: defaults (4:1, depth 8, bypass)
    logic a_flush, a_pv, a_prdy, a_nr, a_nv, a_last, a_af;
    logic [31:0] a_pd;
    logic [7:0]  a_nd;
    logic [3:0]  a_occ;
    // B: 4:2 ratio, depth 5, afull 4, bypass
    logic b_flush, b_pv, b_prdy, b_nr, b_nv, b_last, b_af;
    logic [31:0] b_pd;
    logic [15:0] b_nd;
    logic [2:0]  b_occ;
    // C: defaults without bypass
    logic c_flush, c_pv, c_prdy, c_nr, c_nv, c_last, c_af;
    logic [31:0] c_pd;
    logic [7:0]  c_nd;
    logic [3:0]  c_occ;

    channel_serial_buffer u_dut_a (
        .i_clk(clk), .i_rst(rst), .i_flush(a_flush),
        .i_prev_layer_valid(a_pv), .o_prev_layer_rdy(a_prdy), .i_prev_layer_data(a_pd),
        .i_next_layer_rdy(a_nr), .o_next_layer_valid(a_nv), .o_next_layer_data(a_nd),
        .o_next_layer_last(a_last), .o_occupancy(a_occ), .o_almost_full(a_af)
    );

    channel_serial_buffer #(
        .OUT_CHANNEL(2), .BUFFER_DEPTH(5), .AFULL_THRESH(4)
    ) u_dut_b (
        .i_clk(clk), .i_rst(rst), .i_flush(b_flush),
        .i_prev_layer_valid(b_pv), .o_prev_layer_rdy(b_prdy), .i_prev_layer_data(b_pd),
        .i_next_layer_rdy(b_nr), .o_next_layer_valid(b_nv), .o_next_layer_data(b_nd),
        .o_next_layer_last(b_last), .o_occupancy(b_occ), .o_almost_full(b_af)
    );

    channel_serial_buffer #(
        .BYPASS_EN(1'b0)
    ) u_dut_c (
        .i_clk(clk), .i_rst(rst), .i_flush(c_flush),
        .i_prev_layer_valid(c_pv), .o_prev_layer_rdy(c_prdy), .i_prev_layer_data(c_pd),
        .i_next_layer_rdy(c_nr), .o_next_layer_valid(c_nv), .o_next_layer_data(c_nd),
        .o_next_layer_last(c_last), .o_occupancy(c_occ), .o_almost_full(c_af)
    );

    task automatic idle_inputs();
        a_flush = 0; a_pv = 0; a_pd = '0; a_nr = 0;
        b_flush = 0; b_pv = 0; b_pd = '0; b_nr = 0;
        c_flush = 0; c_pv = 0; c_pd = '0; c_nr = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (a_occ !== 4'd0) begin failures++; $display("FAIL reset_occ got=%0d exp=0", a_occ); end
        checks++; if (a_af !== 1'b0) begin failures++; $display("FAIL reset_afull got=%b exp=0", a_af); end
        checks++; if (a_prdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%b exp=1", a_prdy); end
        checks++; if (a_nv !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", a_nv); end
        checks++; if (a_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%b exp=0", a_last); end
        checks++; if (a_nd !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", a_nd); end
        checks++; if (b_nd !== 16'h0 || b_prdy !== 1'b1 || c_prdy !== 1'b1) begin
            failures++; $display("FAIL reset_other got=%h/%b/%b exp=0000/1/1", b_nd, b_prdy, c_prdy);
        end
        rst = 1'b0;
    endtask

    task automatic test_single_word();
        logic [31:0] w;
        w = 32'h44332211;
        do_reset();
        @(negedge clk);
        a_nr = 1; a_pv = 1; a_pd = w;
        #1;
        checks++; if (a_nv !== 1'b0) begin failures++; $display("FAIL single_prevalid got=%b exp=0", a_nv); end
        @(negedge clk);
        a_pv = 0;
        #1;
        for (int s = 0; s < 4; s++) begin
            checks++;
            if (a_nv !== 1'b1 || a_nd !== w[s*8 +: 8] || a_last !== (s == 3) || a_occ !== 4'd0) begin
                failures++;
                $display("FAIL single_slice%0d got v=%b d=%h l=%b o=%0d exp v=1 d=%h l=%b o=0",
                         s, a_nv, a_nd, a_last, a_occ, w[s*8 +: 8], (s == 3));
            end
            @(negedge clk);
            #1;
        end
        checks++; if (a_nv !== 1'b0) begin failures++; $display("FAIL single_done_valid got=%b exp=0", a_nv); end
    endtask

    task automatic test_fill_stall();
        logic [31:0] words [10];
        logic [31:0] tmp;
        int exp_occ, slices, cyc;
        logic in_fire;
        do_reset();
        a_nr = 0;
        exp_occ = 0;
        for (int i = 0; i < 10; i++) words[i] = $urandom;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_pv = 1; a_pd = words[i];
            #1;
            checks++;
            if (a_prdy !== (i < 9) || a_occ !== exp_occ[3:0] || a_af !== (exp_occ >= 6)) begin
                failures++;
                $display("FAIL fill_word%0d got rdy=%b occ=%0d af=%b exp rdy=%b occ=%0d af=%b",
                         i, a_prdy, a_occ, a_af, (i < 9), exp_occ, (exp_occ >= 6));
            end
            if (i > 0 && i < 9) exp_occ++;
        end
        a_nr = 1;
        slices = 0;
        cyc = 0;
        while (slices < 40 && cyc < 200) begin
            if (a_nv && a_nr) begin
                tmp = words[slices / 4];
                checks++;
                if (a_nd !== tmp[(slices % 4)*8 +: 8] || a_last !== ((slices % 4) == 3)) begin
                    failures++;
                    $display("FAIL drain_slice%0d got d=%h l=%b exp d=%h l=%b", slices, a_nd, a_last,
                             tmp[(slices % 4)*8 +: 8], ((slices % 4) == 3));
                end
                slices++;
            end
            in_fire = a_pv && a_prdy;
            @(negedge clk);
            if (in_fire) a_pv = 0;
            #1;
            cyc++;
        end
        checks++; if (slices != 40) begin failures++; $display("FAIL drain_count got=%0d exp=40", slices); end
        checks++; if (a_nv !== 1'b0 || a_occ !== 4'd0) begin
            failures++; $display("FAIL drain_idle got v=%b occ=%0d exp v=0 occ=0", a_nv, a_occ);
        end
    endtask

    task automatic test_random_ratio2();
        logic [31:0] q [$];
        logic [31:0] head;
        int slice, words_in, words_out, cyc, exp_occ;
        logic acc;
        do_reset();
        slice = 0; words_in = 0; words_out = 0; cyc = 0; acc = 0;
        while (words_out < 1000 && cyc < 20000) begin
            @(negedge clk);
            if (acc) b_pv = 0;
            acc = 0;
            if (!b_pv && words_in < 1000 && $urandom_range(0, 3) != 0) begin
                b_pv = 1; b_pd = $urandom;
            end
            b_nr = ($urandom_range(0, 2) != 0);
            #1;
            exp_occ = q.size() - (b_nv ? 1 : 0);
            checks++;
            if (b_occ !== exp_occ[2:0] || b_af !== (exp_occ >= 4)) begin
                failures++;
                $display("FAIL rand_occ cyc%0d got occ=%0d af=%b exp occ=%0d af=%b",
                         cyc, b_occ, b_af, exp_occ, (exp_occ >= 4));
            end
            if (b_nv) begin
                checks++;
                if (q.size() == 0) begin
                    failures++; $display("FAIL rand_spurious cyc%0d got valid=1 exp valid=0", cyc);
                end else begin
                    head = q[0];
                    if (b_nd !== head[slice*16 +: 16] || b_last !== (slice == 1)) begin
                        failures++;
                        $display("FAIL rand_data word%0d got d=%h l=%b exp d=%h l=%b", words_out,
                                 b_nd, b_last, head[slice*16 +: 16], (slice == 1));
                    end
                    if (b_nr) begin
                        slice++;
                        if (slice == 2) begin
                            void'(q.pop_front());
                            slice = 0;
                            words_out++;
                        end
                    end
                end
            end
            if (b_pv && b_prdy) begin
                q.push_back(b_pd);
                words_in++;
                acc = 1;
            end
            cyc++;
        end
        @(negedge clk);
        b_pv = 0; b_nr = 0;
        #1;
        checks++; if (words_out != 1000 || q.size() != 0 || b_nv !== 1'b0) begin
            failures++;
            $display("FAIL rand_total got out=%0d left=%0d v=%b exp out=1000 left=0 v=0",
                     words_out, q.size(), b_nv);
        end
    endtask

    task automatic test_push_pop_full();
        int cyc;
        do_reset();
        a_nr = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a_pv = 1; a_pd = $urandom;
        end
        @(negedge clk);
        a_pv = 0;
        #1;
        checks++; if (a_occ !== 4'd7) begin failures++; $display("FAIL pp_setup_occ got=%0d exp=7", a_occ); end
        a_nr = 1;
        cyc = 0;
        do begin
            @(negedge clk);
            #1;
            cyc++;
        end while (!a_last && cyc < 10);
        checks++; if (a_last !== 1'b1 || a_prdy !== 1'b1) begin
            failures++; $display("FAIL pp_last got l=%b rdy=%b exp l=1 rdy=1", a_last, a_prdy);
        end
        a_pv = 1; a_pd = $urandom;
        @(negedge clk);
        a_pv = 0; a_nr = 0;
        #1;
        checks++; if (a_occ !== 4'd7) begin failures++; $display("FAIL pp_occ got=%0d exp=7", a_occ); end
    endtask

    task automatic test_no_bypass();
        logic [31:0] w;
        w = $urandom;
        do_reset();
        @(negedge clk);
        c_nr = 1; c_pv = 1; c_pd = w;
        #1;
        checks++; if (c_nv !== 1'b0) begin failures++; $display("FAIL nb_cycle0 got v=%b exp v=0", c_nv); end
        @(negedge clk);
        c_pv = 0;
        #1;
        checks++; if (c_nv !== 1'b0 || c_occ !== 4'd1) begin
            failures++; $display("FAIL nb_cycle1 got v=%b occ=%0d exp v=0 occ=1", c_nv, c_occ);
        end
        @(negedge clk);
        #1;
        checks++; if (c_nv !== 1'b1 || c_nd !== w[7:0] || c_occ !== 4'd0) begin
            failures++;
            $display("FAIL nb_cycle2 got v=%b d=%h occ=%0d exp v=1 d=%h occ=0", c_nv, c_nd, c_occ, w[7:0]);
        end
    endtask

    task automatic test_flush();
        logic [31:0] w0, nw;
        w0 = $urandom;
        nw = $urandom;
        do_reset();
        a_nr = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            a_pv = 1; a_pd = (i == 0) ? w0 : $urandom;
        end
        @(negedge clk);
        a_pv = 0; a_nr = 1;
        #1;
        checks++; if (a_occ !== 4'd5) begin failures++; $display("FAIL flush_setup_occ got=%0d exp=5", a_occ); end
        @(negedge clk);
        @(negedge clk);
        #1;
        checks++; if (a_nd !== w0[23:16]) begin
            failures++; $display("FAIL flush_sel2 got d=%h exp d=%h", a_nd, w0[23:16]);
        end
        a_flush = 1; a_pv = 1; a_pd = $urandom;
        #1;
        checks++; if (a_nv !== 1'b0 || a_prdy !== 1'b0) begin
            failures++; $display("FAIL flush_comb got v=%b rdy=%b exp v=0 rdy=0", a_nv, a_prdy);
        end
        @(negedge clk);
        a_flush = 0; a_pv = 0;
        #1;
        checks++; if (a_occ !== 4'd0 || a_prdy !== 1'b1 || a_nv !== 1'b0) begin
            failures++;
            $display("FAIL flush_after got occ=%0d rdy=%b v=%b exp occ=0 rdy=1 v=0", a_occ, a_prdy, a_nv);
        end
        a_pv = 1; a_pd = nw;
        @(negedge clk);
        a_pv = 0;
        #1;
        checks++; if (a_nv !== 1'b1 || a_nd !== nw[7:0] || a_last !== 1'b0) begin
            failures++;
            $display("FAIL flush_newword got v=%b d=%h l=%b exp v=1 d=%h l=0", a_nv, a_nd, a_last, nw[7:0]);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] nw;
        int got;
        nw = $urandom;
        do_reset();
        a_nr = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_pv = 1; a_pd = $urandom;
        end
        @(negedge clk);
        a_pv = 0; a_nr = 1;
        @(negedge clk);
        a_nr = 0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (a_nv !== 1'b0 || a_nd !== 8'h00 || a_last !== 1'b0 || a_occ !== 4'd0 ||
            a_af !== 1'b0 || a_prdy !== 1'b1) begin
            failures++;
            $display("FAIL arst_outputs got v=%b d=%h l=%b occ=%0d af=%b rdy=%b exp 0/00/0/0/0/1",
                     a_nv, a_nd, a_last, a_occ, a_af, a_prdy);
        end
        @(negedge clk);
        rst = 1'b0;
        a_pv = 1; a_pd = nw; a_nr = 1;
        @(negedge clk);
        a_pv = 0;
        got = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (a_nv) begin
                checks++;
                if (got >= 4 || a_nd !== nw[got*8 +: 8]) begin
                    failures++; $display("FAIL arst_post slice%0d got d=%h exp d=%h", got, a_nd, nw[got*8 +: 8]);
                end
                got++;
            end
            @(negedge clk);
        end
        checks++; if (got != 4) begin failures++; $display("FAIL arst_post_count got=%0d exp=4", got); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_word();
        test_fill_stall();
        test_random_ratio2();
        test_push_pop_full();
        test_no_bypass();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
